led_code_player: RTL and testbench
==================================

Name: led_code_player

Overview:
- Receiving end of the switch priority-encoder path.
- Accepts 3-bit LED codes with a valid strobe and buffers them in a small FIFO.
- Plays each code back, oldest first, as a one-hot LED pattern plus a 7-segment digit for a fixed hold time, followed by a blank gap.
- Sits between encoder/switch logic and board LEDs/HEX display.

Parameters:
- DEPTH, 8: FIFO entries; power of two, ≥2.
- HOLD, 50000000: cycles each code is displayed; ≥1.
- GAP, 12500000: blank cycles after each display; ≥1.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  code present on in_code.
- in_code  in  3  code to play, 0..7.
- in_ready  out  1  FIFO can accept; = !full, driven from registered count.
- ledr  out  8  one-hot display; bit in_code set during SHOW, else 0.
- seg0  out  8  active-low 7-seg {dp,g,f,e,d,c,b,a}; dp always 1.
- busy  out  1  1 in SHOW or GAP.
- count  out  log2(DEPTH)+1  FIFO occupancy.
- ovf  out  1  sticky; set when in_valid=1 and in_ready=0.

Behaviour:
- Reset (rst=0, async): FIFO pointers and count = 0, state = IDLE, timer = 0, display register = 0. Outputs: ledr = 0, seg0 = 8'hFF, busy = 0, ovf = 0, in_ready = 1.
- Push: occurs on a clk edge when in_valid && in_ready. Writes in_code at wr_ptr; wr_ptr wraps modulo DEPTH.
- in_valid while full: code dropped, FIFO unchanged, ovf set. ovf is cleared only by reset.
- Pop: occurs only in IDLE when count≠0. Reads rd_ptr into the display register; rd_ptr wraps modulo DEPTH.
- Simultaneous push and pop: count unchanged.
- Push when count=DEPTH-1 with no pop: count→DEPTH, in_ready→0 next cycle.
- Pop when full: in_ready rises the cycle after; a same-cycle push is refused because in_ready was 0.
- State machine (registered):
  - IDLE: if count≠0, pop, timer←0, →SHOW; else stay.
  - SHOW: ledr = 1<<code; seg0 = digit pattern. Timer increments; at timer=HOLD-1, timer←0, →GAP. Duration is exactly HOLD cycles.
  - GAP: ledr = 0, seg0 = 8'hFF. Timer increments; at timer=GAP-1, timer←0, →IDLE. Duration is exactly GAP cycles.
- Latency: push at edge t into an empty FIFO with state IDLE → pop at edge t+1 → ledr/seg0 valid from edge t+1 onward (registered outputs update at t+1). Back-to-back codes are separated by GAP+1 cycles (GAP cycles blank, one IDLE cycle).
- All of ledr, seg0 and busy are registered, with no combinational path from inputs.
- Digit patterns for seg0[6:0] (dp=1, so seg0 shown in full):
  - 0 = 8'hC0, 1 = 8'hF9, 2 = 8'hA4, 3 = 8'hB0
  - 4 = 8'h99, 5 = 8'h92, 6 = 8'h82, 7 = 8'hF8
- Timer width: ceil(log2(max(HOLD,GAP))) bits; it never exceeds the compare value.
- Reset mid-SHOW or mid-GAP: outputs blank immediately (async); FIFO contents are discarded.
- FIFO memory is not reset; only pointers, count and the display register are.

Test Plan (HOLD=4, GAP=2, DEPTH=4):
- Reset then idle 10 cycles → ledr=0, seg0=8'hFF, busy=0, in_ready=1, count=0.
- Single push code 5 → next edge ledr=8'h20, seg0=8'h92, busy=1 for exactly 4 cycles; then 2 cycles ledr=0, seg0=8'hFF, busy=1; then busy=0, count=0.
- Push codes 0,3,7 on consecutive cycles → played in order 8'h01/8'hC0, 8'h08/8'hB0, 8'h80/8'hF8, each 4 cycles, with 3 cycles between SHOW windows.
- Push 6 codes back-to-back with in_valid held → first pops immediately, then FIFO fills: count reaches 4, in_ready=0, 6th code dropped, ovf=1. ovf stays 1 after FIFO drains.
- Steady state full, with push and pop on the same edge → count stays 4, wr_ptr/rd_ptr wrap past 3→0, no data corruption in later playback.
- Assert rst=0 two cycles into SHOW of code 2 → ledr=0, seg0=8'hFF, count=0 immediately. After release, push code 1 → ledr=8'h02, seg0=8'hF9.

Source files
------------

// File: rtl/led_code_player.sv
// LED code player: buffers 3-bit codes in a FIFO and plays each back as a
// one-hot LED pattern plus a 7-segment digit for HOLD cycles, then blanks for GAP cycles.
module led_code_player #(
    parameter int DEPTH = 8,
    parameter int HOLD  = 50000000,
    parameter int GAP   = 12500000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [2:0]               in_code,
    output logic                     in_ready,
    output logic [7:0]               ledr,
    output logic [7:0]               seg0,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int AW   = $clog2(DEPTH);
    localparam int MAXT = (HOLD > GAP) ? HOLD : GAP;
    localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP - 1);
    localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

    state_t          state, state_nx;
    logic [TW-1:0]   timer, timer_nx;
    logic [2:0]      code, code_nx;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [2:0]      mem [DEPTH];
    logic            push, pop;
    logic [7:0]      ledr_nx, seg_nx;
    logic            busy_nx;

    assign in_ready = (count != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_IDLE) && (count != '0);

    // Storage is deliberately left out of reset; only pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_code;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (in_valid && !in_ready) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            timer <= '0;
            code  <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            code  <= code_nx;
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        code_nx  = code;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    code_nx  = mem[rd_ptr];
                    timer_nx = '0;
                    state_nx = S_SHOW;
                end
            end
            S_SHOW: begin
                if (timer == HOLD_LAST) begin
                    timer_nx = '0;
                    state_nx = S_GAP;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            S_GAP: begin
                if (timer == GAP_LAST) begin
                    timer_nx = '0;
                    state_nx = S_IDLE;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            default: begin
                timer_nx = '0;
                state_nx = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered display lines up with the pop edge.
    always_comb begin
        ledr_nx = '0;
        seg_nx  = 8'hFF;
        busy_nx = (state_nx != S_IDLE);
        if (state_nx == S_SHOW) begin
            ledr_nx = 8'b1 << code_nx;
            case (code_nx)
                3'd0:    seg_nx = 8'hC0;
                3'd1:    seg_nx = 8'hF9;
                3'd2:    seg_nx = 8'hA4;
                3'd3:    seg_nx = 8'hB0;
                3'd4:    seg_nx = 8'h99;
                3'd5:    seg_nx = 8'h92;
                3'd6:    seg_nx = 8'h82;
                default: seg_nx = 8'hF8;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ledr <= '0;
            seg0 <= 8'hFF;
            busy <= 1'b0;
        end else begin
            ledr <= ledr_nx;
            seg0 <= seg_nx;
            busy <= busy_nx;
        end
    end

endmodule

// File: tb/tb_led_code_player.sv
// Directed self-checking bench for led_code_player with HOLD=4, GAP=2, DEPTH=4.
module tb_led_code_player;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_ready;
    logic [7:0] ledr;
    logic [7:0] seg0;
    logic       busy;
    logic [2:0] count;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    led_code_player #(.DEPTH(4), .HOLD(4), .GAP(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_code  (in_code),
        .in_ready (in_ready),
        .ledr     (ledr),
        .seg0     (seg0),
        .busy     (busy),
        .count    (count),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks n remaining SHOW cycles, the 2 GAP cycles and the single IDLE cycle; ends on the IDLE cycle.
    task automatic show_window(input string tag, input logic [7:0] led, input logic [7:0] seg, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_led"}, ledr, led);
            chk({tag, "_seg"}, seg0, seg);
            chk({tag, "_busy"}, busy, 1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_gap_led"}, ledr, 0);
            chk({tag, "_gap_seg"}, seg0, 8'hFF);
            chk({tag, "_gap_busy"}, busy, 1);
            tick();
        end
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_led"}, ledr, 0);
    endtask

    task automatic wait_show(input string tag);
        int w = 0;
        while (ledr == 8'h00 && w < 20) begin
            tick();
            w++;
        end
        chk({tag, "_start"}, (ledr != 8'h00), 1);
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_code = 3'd0;

        // Reset state
        tick(); tick();
        chk("rst_ledr", ledr, 0);
        chk("rst_seg", seg0, 8'hFF);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("idle_ledr", ledr, 0);
        chk("idle_seg", seg0, 8'hFF);
        chk("idle_busy", busy, 0);
        chk("idle_ready", in_ready, 1);
        chk("idle_count", count, 0);

        // Single code 5
        in_valid = 1'b1; in_code = 3'd5;
        tick();
        in_valid = 1'b0;
        chk("single_count", count, 1);
        chk("single_prebusy", busy, 0);
        tick();
        show_window("single", 8'h20, 8'h92, 4);
        chk("single_end_count", count, 0);

        // Three consecutive codes 0,3,7
        tick();
        in_valid = 1'b1; in_code = 3'd0;
        tick(); in_code = 3'd3;
        tick(); in_code = 3'd7;
        tick(); in_valid = 1'b0;
        chk("seq_count", count, 2);
        show_window("seq0", 8'h01, 8'hC0, 3);
        tick();
        show_window("seq3", 8'h08, 8'hB0, 4);
        tick();
        show_window("seq7", 8'h80, 8'hF8, 4);
        chk("seq_end_count", count, 0);

        // Overfill: six codes 1..6 back to back, sixth dropped
        tick();
        in_valid = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            in_code = 3'(c);
            tick();
        end
        in_valid = 1'b0;
        chk("ovf_count", count, 4);
        chk("ovf_ready", in_ready, 0);
        chk("ovf_flag", ovf, 1);
        wait_show("ovf2");
        show_window("ovf2", 8'h04, 8'hA4, 4);
        tick();
        show_window("ovf3", 8'h08, 8'hB0, 4);
        tick();
        show_window("ovf4", 8'h10, 8'h99, 4);
        tick();
        show_window("ovf5", 8'h20, 8'h92, 4);
        chk("ovf_drain_count", count, 0);
        chk("ovf_sticky", ovf, 1);
        tick(); tick();
        chk("ovf_idle_nobusy", busy, 0);

        // Full FIFO: push held while full is refused until in_ready rises after the pop
        tick();
        in_valid = 1'b1;
        for (int c = 6; c >= 2; c--) begin
            in_code = 3'(c);
            tick();
        end
        in_code = 3'd1;
        chk("full_count", count, 4);
        chk("full_ready", in_ready, 0);
        begin
            int w = 0;
            while (!in_ready && w < 20) begin
                tick();
                w++;
            end
        end
        chk("full_pop_ready", in_ready, 1);
        chk("full_pop_count", count, 3);
        chk("full_pop_led", ledr, 8'h20);
        tick();
        in_valid = 1'b0;
        chk("full_refill_count", count, 4);
        chk("full_refill_ready", in_ready, 0);
        show_window("wrap5", 8'h20, 8'h92, 3);
        tick();
        show_window("wrap4", 8'h10, 8'h99, 4);
        tick();
        show_window("wrap3", 8'h08, 8'hB0, 4);
        tick();
        show_window("wrap2", 8'h04, 8'hA4, 4);
        tick();
        show_window("wrap1", 8'h02, 8'hF9, 4);
        chk("wrap_end_count", count, 0);

        // Reset two cycles into SHOW of code 2, with code 7 still queued
        tick();
        in_valid = 1'b1; in_code = 3'd2;
        tick(); in_code = 3'd7;
        tick(); in_valid = 1'b0;
        chk("mid_show_led", ledr, 8'h04);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_ledr", ledr, 0);
        chk("mid_rst_seg", seg0, 8'hFF);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_ready", in_ready, 1);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_ledr", ledr, 0);
            chk("post_rst_count", count, 0);
        end
        in_valid = 1'b1; in_code = 3'd1;
        tick();
        in_valid = 1'b0;
        chk("post_rst_push_count", count, 1);
        tick();
        show_window("post_rst1", 8'h02, 8'hF9, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
